// File: rtl/nn_arbiter.sv
// nn_arbiter: round-robin front end that shares one nn inference datapath between N requesters.
// Issues the weight-load pulse after reset, then serves one request at a time with a fixed latency.
module nn_arbiter #(
   parameter int N           = 4,
   parameter int LATENCY     = 6,
   parameter int LOAD_CYCLES = 16,
   localparam int ID_W       = $clog2(N)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [N-1:0]      req_valid,
   output logic [N-1:0]      req_ready,
   input  logic [32*N-1:0]   req_in1,
   input  logic [32*N-1:0]   req_in2,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [ID_W-1:0]   rsp_id,
   output logic [31:0]       rsp_data,
   output logic              rsp_ovf,
   output logic              rsp_zero,
   output logic              nn_enable,
   output logic [31:0]       nn_input_1,
   output logic [31:0]       nn_input_2,
   input  logic [31:0]       nn_final_output,
   input  logic              nn_total_ovf,
   input  logic              nn_total_zero,
   output logic              weights_ready,
   output logic              busy,
   output logic [15:0]       ovf_count
);

   localparam logic [2:0] S_LOAD      = 3'd0;
   localparam logic [2:0] S_LOAD_WAIT = 3'd1;
   localparam logic [2:0] S_IDLE      = 3'd2;
   localparam logic [2:0] S_ISSUE     = 3'd3;
   localparam logic [2:0] S_WAIT      = 3'd4;
   localparam logic [2:0] S_RESP      = 3'd5;

   localparam logic [15:0] LOAD_LAST = 16'(LOAD_CYCLES - 1);
   localparam logic [15:0] LAT_LAST  = 16'(LATENCY - 1);

   logic [2:0]      state;
   logic [15:0]     cnt;
   logic [ID_W-1:0] last_grant;
   logic [ID_W-1:0] cur_id;
   logic [ID_W-1:0] cand;
   logic [ID_W-1:0] win_id;
   logic            win_found;
   logic [N-1:0]    grant;
   logic            transfer;

   // Round-robin search starting one past the previous winner.
   always_comb begin
      cand      = '0;
      win_id    = '0;
      win_found = 1'b0;
      for (int k = 1; k <= N; k++) begin
         cand = ID_W'((int'(last_grant) + k) % N);
         if (!win_found && req_valid[cand]) begin
            win_id    = cand;
            win_found = 1'b1;
         end
      end
      grant = win_found ? (N'(1) << win_id) : '0;
   end

   assign req_ready = (state == S_IDLE) ? grant : '0;
   assign transfer  = |(req_valid & req_ready);

   // The LOAD pulse is gated by resetn so every output reads 0 while reset is held.
   assign nn_enable = (state == S_ISSUE) | ((state == S_LOAD) & resetn);
   assign busy      = (state != S_IDLE) & resetn;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= S_LOAD;
         cnt           <= '0;
         last_grant    <= ID_W'(N - 1);
         cur_id        <= '0;
         nn_input_1    <= '0;
         nn_input_2    <= '0;
         rsp_valid     <= 1'b0;
         rsp_id        <= '0;
         rsp_data      <= '0;
         rsp_ovf       <= 1'b0;
         rsp_zero      <= 1'b0;
         weights_ready <= 1'b0;
         ovf_count     <= '0;
      end else begin
         case (state)
            S_LOAD: begin
               cnt   <= '0;
               state <= S_LOAD_WAIT;
            end
            S_LOAD_WAIT: begin
               if (cnt == LOAD_LAST) begin
                  cnt           <= '0;
                  weights_ready <= 1'b1;
                  state         <= S_IDLE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_IDLE: begin
               if (transfer) begin
                  nn_input_1 <= req_in1[32*win_id +: 32];
                  nn_input_2 <= req_in2[32*win_id +: 32];
                  cur_id     <= win_id;
                  state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               last_grant <= cur_id;
               cnt        <= '0;
               state      <= S_WAIT;
            end
            S_WAIT: begin
               // nn_input_* stay untouched here so the datapath sees stable operands.
               if (cnt == LAT_LAST) begin
                  rsp_data  <= nn_final_output;
                  rsp_ovf   <= nn_total_ovf;
                  rsp_zero  <= nn_total_zero;
                  rsp_id    <= cur_id;
                  rsp_valid <= 1'b1;
                  if (nn_total_ovf && (ovf_count != 16'hFFFF)) begin
                     ovf_count <= ovf_count + 16'd1;
                  end
                  state <= S_RESP;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_nn_arbiter.sv
// Randomized scoreboard bench for nn_arbiter with a fake nn that presents its
// result only in the cycle before the expected capture edge.
module tb_nn_arbiter;

   localparam int N           = 4;
   localparam int LATENCY     = 6;
   localparam int LOAD_CYCLES = 16;
   localparam int ID_W        = 2;

   logic              clk;
   logic              resetn;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [32*N-1:0]   req_in1;
   logic [32*N-1:0]   req_in2;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [ID_W-1:0]   rsp_id;
   logic [31:0]       rsp_data;
   logic              rsp_ovf;
   logic              rsp_zero;
   logic              nn_enable;
   logic [31:0]       nn_input_1;
   logic [31:0]       nn_input_2;
   logic [31:0]       nn_final_output;
   logic              nn_total_ovf;
   logic              nn_total_zero;
   logic              weights_ready;
   logic              busy;
   logic [15:0]       ovf_count;

   nn_arbiter #(.N(N), .LATENCY(LATENCY), .LOAD_CYCLES(LOAD_CYCLES)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_in1(req_in1), .req_in2(req_in2),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero),
      .nn_enable(nn_enable), .nn_input_1(nn_input_1), .nn_input_2(nn_input_2),
      .nn_final_output(nn_final_output), .nn_total_ovf(nn_total_ovf), .nn_total_zero(nn_total_zero),
      .weights_ready(weights_ready), .busy(busy), .ovf_count(ovf_count)
   );

   typedef struct {
      int          id;
      logic [31:0] a;
      logic [31:0] b;
      int          accept_edge;
   } txn_t;

   txn_t        exp_q[$];
   int          grant_log[$];
   int          accept_log[$];
   int          cyc;
   int          checks;
   int          passed;
   int          last_grant_m;
   int          load_done_cyc;
   int          enable_due;
   int          nn_due;
   int          ovf_m;
   bit          outstanding;
   bit          rsp_shown;
   logic [31:0] en_in1, en_in2;
   logic [31:0] nn_a, nn_b;
   int          held_id;
   logic [31:0] held_data;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic flag_fail(input string name);
      checks++;
      $display("[TB] FAIL %s: got no event required event (cycle %0d)", name, cyc);
   endtask

   // Reference nn: wrapping 32-bit add with signed overflow and zero flags, packed {zero, ovf, sum}.
   function automatic logic [33:0] nn_ref(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] s;
      logic        o;
      s = a + b;
      o = (a[31] == b[31]) && (s[31] != a[31]);
      return {(s == 32'd0), o, s};
   endfunction

   function automatic int rr_winner(input logic [N-1:0] v, input int lg);
      for (int k = 1; k <= N; k++) begin
         if (v[(lg + k) % N]) return (lg + k) % N;
      end
      return -1;
   endfunction

   // Monitor, scoreboard and fake nn, all sampled on the falling edge.
   initial begin
      logic [33:0] r;
      txn_t        t;
      int          w;
      bit          idle_m;
      logic [N-1:0] exp_ready;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            check_output("reset_ctrl", 32'({req_ready, rsp_valid, rsp_id, rsp_ovf, rsp_zero, nn_enable, weights_ready, busy}), 32'd0);
            check_output("reset_data", rsp_data | nn_input_1 | nn_input_2 | 32'(ovf_count), 32'd0);
         end else begin
            idle_m    = (cyc >= load_done_cyc) && !outstanding;
            w         = idle_m ? rr_winner(req_valid, last_grant_m) : -1;
            exp_ready = (w >= 0) ? N'(1 << w) : '0;
            check_output("req_ready", 32'(req_ready), 32'(exp_ready));
            check_output("weights_ready", 32'(weights_ready), 32'(cyc >= load_done_cyc));
            check_output("busy", 32'(busy), 32'(!idle_m));
            check_output("nn_enable", 32'(nn_enable), 32'(cyc == enable_due));
            if (cyc == enable_due) begin
               check_output("nn_input_1", nn_input_1, en_in1);
               check_output("nn_input_2", nn_input_2, en_in2);
            end
            if (w >= 0) begin
               t.id          = w;
               t.a           = req_in1[32*w +: 32];
               t.b           = req_in2[32*w +: 32];
               t.accept_edge = cyc + 1;
               exp_q.push_back(t);
               grant_log.push_back(w);
               accept_log.push_back(cyc + 1);
               outstanding  = 1'b1;
               last_grant_m = w;
               enable_due   = cyc + 1;
               en_in1       = t.a;
               en_in2       = t.b;
            end
            if (rsp_valid) begin
               if (!rsp_shown) begin
                  if (exp_q.size() == 0) begin
                     flag_fail("unexpected_rsp");
                  end else begin
                     t = exp_q.pop_front();
                     r = nn_ref(t.a, t.b);
                     check_output("rsp_latency", cyc, t.accept_edge + LATENCY + 1);
                     check_output("rsp_id", 32'(rsp_id), t.id);
                     check_output("rsp_data", rsp_data, r[31:0]);
                     check_output("rsp_ovf", 32'(rsp_ovf), 32'(r[32]));
                     check_output("rsp_zero", 32'(rsp_zero), 32'(r[33]));
                     if (r[32] && ovf_m < 65535) ovf_m++;
                     check_output("ovf_count", 32'(ovf_count), ovf_m);
                     held_id   = t.id;
                     held_data = r[31:0];
                  end
                  rsp_shown = 1'b1;
               end else begin
                  check_output("rsp_hold_id", 32'(rsp_id), held_id);
                  check_output("rsp_hold_data", rsp_data, held_data);
               end
               if (rsp_ready) begin
                  rsp_shown   = 1'b0;
                  outstanding = 1'b0;
               end
            end else if (rsp_shown) begin
               flag_fail("rsp_dropped");
               rsp_shown   = 1'b0;
               outstanding = 1'b0;
            end
            if (nn_enable) begin
               nn_due = cyc + LATENCY;
               nn_a   = nn_input_1;
               nn_b   = nn_input_2;
            end
         end
         if (resetn && cyc == nn_due) begin
            r = nn_ref(nn_a, nn_b);
            nn_final_output = r[31:0];
            nn_total_ovf    = r[32];
            nn_total_zero   = r[33];
         end else begin
            nn_final_output = $urandom;
            nn_total_ovf    = 1'($urandom_range(0, 1));
            nn_total_zero   = 1'($urandom_range(0, 1));
         end
      end
   end

   task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
      req_in1[32*i +: 32] = a;
      req_in2[32*i +: 32] = b;
   endtask

   task automatic apply_stimulus();
      int mode;
      logic [31:0] a;
      req_valid = N'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) begin
         mode = $urandom_range(0, 3);
         a    = $urandom;
         if (mode == 0)      set_ops(i, a, -a);
         else if (mode == 1) set_ops(i, 32'h7FFF0000 | a[15:0], 32'h7FFF0000);
         else                set_ops(i, a, $urandom);
      end
   endtask

   task automatic reset_assert();
      @(posedge clk);
      #1;
      resetn = 1'b0;
      #1;
      check_output("async_reset_ctrl", 32'({req_ready, rsp_valid, nn_enable, weights_ready, busy}), 32'd0);
      check_output("async_reset_cnt", 32'(ovf_count), 32'd0);
      exp_q.delete();
      outstanding   = 1'b0;
      rsp_shown     = 1'b0;
      enable_due    = -1;
      nn_due        = -1;
      load_done_cyc = 1 << 30;
      last_grant_m  = N - 1;
      ovf_m         = 0;
   endtask

   task automatic reset_release(output int rel);
      @(posedge clk);
      #1;
      resetn        = 1'b1;
      rel           = cyc;
      load_done_cyc = cyc + LOAD_CYCLES + 1;
      enable_due    = cyc;
      en_in1        = '0;
      en_in2        = '0;
   endtask

   task automatic wait_loaded(input int rel);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (weights_ready) begin
            check_output("load_time", cyc - rel, LOAD_CYCLES + 1);
            return;
         end
      end
      flag_fail("load_timeout");
   endtask

   task automatic wait_grants(input int target, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (grant_log.size() >= target) return;
         @(posedge clk);
         #1;
      end
      if (grant_log.size() < target) flag_fail("grant_timeout");
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200; i++) begin
         if (!outstanding && exp_q.size() == 0) begin
            @(posedge clk);
            #1;
            return;
         end
         @(posedge clk);
         #1;
      end
      flag_fail("drain_timeout");
   endtask

   initial begin
      int rel;
      int base;
      int ovf_before;
      int exp_order[6];
      exp_order = '{0, 1, 2, 3, 0, 1};
      checks = 0; passed = 0;
      resetn = 1'b1; req_valid = '0; req_in1 = '0; req_in2 = '0; rsp_ready = 1'b1;
      outstanding = 1'b0; rsp_shown = 1'b0; enable_due = -1; nn_due = -1;
      load_done_cyc = 1 << 30; last_grant_m = N - 1; ovf_m = 0;
      nn_final_output = '0; nn_total_ovf = 1'b0; nn_total_zero = 1'b0;
      #1 resetn = 1'b0;

      // Requests wait through the load sequence, then rotate 0,1,2,3,0,1.
      $display("[TB] reset release and round-robin burst");
      req_valid = '1;
      for (int i = 0; i < N; i++) set_ops(i, $urandom, $urandom);
      repeat (3) @(posedge clk);
      reset_release(rel);
      wait_loaded(rel);
      wait_grants(6, 100);
      req_valid = '0;
      if (grant_log.size() >= 6) begin
         for (int i = 0; i < 6; i++) check_output("grant_order", grant_log[i], exp_order[i]);
         for (int i = 1; i < 6; i++) check_output("accept_spacing", accept_log[i] - accept_log[i-1], LATENCY + 3);
      end
      wait_drain();

      $display("[TB] single request from requester 2");
      base = grant_log.size();
      set_ops(2, 32'd100, -32'sd50);
      req_valid = 4'b0100;
      wait_grants(base + 1, 40);
      req_valid = '0;
      if (grant_log.size() > base) check_output("single_grant", grant_log[base], 2);
      wait_drain();

      $display("[TB] back-pressure on the response port");
      base = grant_log.size();
      rsp_ready = 1'b0;
      req_valid = '1;
      for (int i = 0; i < N; i++) set_ops(i, $urandom, $urandom);
      wait_grants(base + 1, 40);
      for (int i = 0; i < 20 && !rsp_valid; i++) begin
         @(posedge clk);
         #1;
      end
      check_output("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      repeat (5) @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      req_valid = '0;
      check_output("bp_released", 32'(rsp_valid), 32'd0);
      wait_drain();

      $display("[TB] randomized traffic");
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #1;
         apply_stimulus();
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      wait_drain();

      $display("[TB] reset during WAIT");
      base = grant_log.size();
      set_ops(1, $urandom, $urandom);
      req_valid = 4'b0010;
      wait_grants(base + 1, 40);
      req_valid = '0;
      repeat (3) @(posedge clk);
      reset_assert();
      req_valid = '1;
      repeat (2) @(posedge clk);
      reset_release(rel);
      wait_loaded(rel);
      base = grant_log.size();
      wait_grants(base + 1, 40);
      req_valid = '0;
      if (grant_log.size() > base) check_output("first_after_reset", grant_log[base], 0);
      wait_drain();

      $display("[TB] overflow response");
      base       = grant_log.size();
      ovf_before = ovf_m;
      set_ops(1, 32'h7FFFFFF0, 32'h7FFFFFF0);
      req_valid = 4'b0010;
      wait_grants(base + 1, 40);
      req_valid = '0;
      wait_drain();
      check_output("ovf_increment", 32'(ovf_count), ovf_before + 1);

      check_output("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
